// File: rtl/pc_unit_ras_pkg.sv
// Shared defaults and redirect-source encoding for the PC unit with return-address stack.
package pc_unit_ras_pkg;

  localparam int          DEF_SIZE      = 32;
  localparam int          DEF_INC       = 4;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0080;
  localparam int          DEF_RAS_DEPTH = 4;

  // Where the next pc comes from, in decreasing priority order.
  typedef enum logic [3:0] {
    RST,
    TRAP,
    HOLD,
    TAIL,
    CALL,
    RET,
    RET_UNF,
    BR,
    SEQ
  } redirect_src_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a write pointer plus an occupancy count.
// When full, a push lands on the oldest slot, so the newest entries survive.
module ras_stack
  import pc_unit_ras_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic            replace,
  input  logic [SIZE-1:0] wdata,
  output logic [SIZE-1:0] rdata,
  output logic            empty,
  output logic            full,
  output logic            ovf_evt
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [SIZE-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count_q;

  assign top_ptr = wr_ptr_q - PW'(1);
  assign rdata   = stack_q[top_ptr];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(RAS_DEPTH));
  assign ovf_evt = push & full;

  // Pointer and count: push wins over pop; a pop on an empty stack is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (!full) count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      wr_ptr_q <= wr_ptr_q - PW'(1);
      count_q  <= count_q - CW'(1);
    end
  end

  // Stack storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[wr_ptr_q] <= wdata;
    end else if (replace) begin
      stack_q[top_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with sequential, branch, call/return, trap and stall handling.
module pc_unit_ras
  import pc_unit_ras_pkg::*;
#(
  parameter int              SIZE      = DEF_SIZE,
  parameter int              INC       = DEF_INC,
  parameter logic [SIZE-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [SIZE-1:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic [SIZE-1:0] branch_target,
  output logic [SIZE-1:0] pc,
  output logic [SIZE-1:0] pc_4,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_unf
);

  redirect_src_e   src;
  logic [SIZE-1:0] pc_next;
  logic [SIZE-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_replace;
  logic            ovf_evt;
  logic            set_unf;

  assign pc_4 = pc + SIZE'(INC);

  ras_stack #(
    .SIZE      (SIZE),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (ras_push),
    .pop     (ras_pop),
    .replace (ras_replace),
    .wdata   (pc_4),
    .rdata   (ras_top),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf_evt (ovf_evt)
  );

  // Priority decode of the redirect source, first match wins.
  always_comb begin
    src = SEQ;
    if (reset)                  src = RST;
    else if (trap)              src = TRAP;
    else if (stall)             src = HOLD;
    else if (call && ret)       src = TAIL;
    else if (call)              src = CALL;
    else if (ret && !ras_empty) src = RET;
    else if (ret)               src = RET_UNF;
    else if (branch)            src = BR;
  end

  // Next pc and stack commands for the selected source.
  always_comb begin
    pc_next     = pc_4;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    set_unf     = 1'b0;
    unique case (src)
      RST:     pc_next = RESET_VEC;
      TRAP:    pc_next = TRAP_VEC;
      HOLD:    pc_next = pc;
      TAIL: begin
        // A tail call reuses the caller's slot; with nothing to reuse it is a push.
        pc_next     = branch_target;
        ras_push    = ras_empty;
        ras_replace = !ras_empty;
      end
      CALL: begin
        pc_next  = branch_target;
        ras_push = 1'b1;
      end
      RET: begin
        pc_next = ras_top;
        ras_pop = 1'b1;
      end
      RET_UNF: begin
        pc_next = pc_4;
        set_unf = 1'b1;
      end
      BR:      pc_next = branch_target;
      default: pc_next = pc_4;
    endcase
  end

  // Fetch address register.
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_VEC;
    else       pc <= pc_next;
  end

  // Sticky overflow/underflow flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      if (ovf_evt) ras_ovf <= 1'b1;
      if (set_unf) ras_unf <= 1'b1;
    end
  end

endmodule
